// File: rtl/life_manager.sv
// Player-life manager: counts lives, drives a thermometer LED bar, handles a
// post-hit invulnerability window with blinking LEDs, bonus lives and restart.
module life_manager #(
  parameter int MAX_LIVES     = 3,
  parameter int START_LIVES   = 3,
  parameter int INVULN_CYCLES = 25000000,
  parameter int BLINK_CYCLES  = 2500000,
  parameter int LW            = $clog2(MAX_LIVES + 1)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 game_start,
  input  logic                 hit,
  input  logic                 bonus,
  output logic [LW-1:0]        lives,
  output logic [MAX_LIVES-1:0] lives_led,
  output logic                 invuln,
  output logic                 hit_ack,
  output logic                 die
);

  localparam int IW = (INVULN_CYCLES > 1) ? $clog2(INVULN_CYCLES) : 1;
  localparam int BW = (BLINK_CYCLES > 1) ? $clog2(BLINK_CYCLES) : 1;

  localparam logic [IW-1:0]        INV_LOAD  = IW'(INVULN_CYCLES - 1);
  localparam logic [BW-1:0]        BLK_LOAD  = BW'(BLINK_CYCLES - 1);
  localparam logic [LW-1:0]        START_L   = LW'(START_LIVES);
  localparam logic [LW-1:0]        MAX_L     = LW'(MAX_LIVES);
  localparam logic [MAX_LIVES-1:0] START_LED = {MAX_LIVES{1'b1}} >> (MAX_LIVES - START_LIVES);

  typedef enum logic [1:0] {ALIVE, INVULN, DEAD} state_t;

  state_t                 state, state_nxt;
  logic [LW-1:0]          lives_nxt;
  logic [IW-1:0]          inv_timer, inv_nxt;
  logic [BW-1:0]          blink_timer, blk_nxt;
  logic                   blink_on, blink_nxt;
  logic                   hit_q, bonus_q;
  logic                   ack_nxt;
  logic [MAX_LIVES-1:0]   led_nxt;
  logic                   hit_rise, bonus_rise;

  assign hit_rise   = hit & ~hit_q;
  assign bonus_rise = bonus & ~bonus_q;

  always_comb begin
    state_nxt = state;
    lives_nxt = lives;
    inv_nxt   = inv_timer;
    blk_nxt   = blink_timer;
    blink_nxt = blink_on;
    ack_nxt   = 1'b0;
    led_nxt   = '0;

    if (game_start) begin
      state_nxt = ALIVE;
      lives_nxt = START_L;
      inv_nxt   = '0;
      blk_nxt   = '0;
      blink_nxt = 1'b1;
    end else begin
      case (state)
        ALIVE: begin
          if (hit_rise) begin
            ack_nxt = 1'b1;
            if (!bonus_rise && lives == LW'(1)) begin
              lives_nxt = '0;
              state_nxt = DEAD;
            end else begin
              // a simultaneous bonus cancels the life loss but the hit still opens the window
              if (!bonus_rise) lives_nxt = lives - LW'(1);
              state_nxt = INVULN;
              inv_nxt   = INV_LOAD;
              blk_nxt   = BLK_LOAD;
              blink_nxt = 1'b0;
            end
          end else if (bonus_rise && lives < MAX_L) begin
            lives_nxt = lives + LW'(1);
          end
        end
        INVULN: begin
          if (bonus_rise && lives < MAX_L) lives_nxt = lives + LW'(1);
          if (blink_timer == '0) begin
            blk_nxt   = BLK_LOAD;
            blink_nxt = ~blink_on;
          end else begin
            blk_nxt = blink_timer - BW'(1);
          end
          if (inv_timer == '0) begin
            state_nxt = ALIVE;
            blink_nxt = 1'b1;
          end else begin
            inv_nxt = inv_timer - IW'(1);
          end
        end
        DEAD: begin
          lives_nxt = '0;
        end
        default: state_nxt = ALIVE;
      endcase
    end

    for (int unsigned i = 0; i < MAX_LIVES; i++) begin
      led_nxt[i] = (i < 32'(lives_nxt)) && blink_nxt;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= ALIVE;
      lives       <= START_L;
      lives_led   <= START_LED;
      invuln      <= 1'b0;
      hit_ack     <= 1'b0;
      die         <= 1'b0;
      inv_timer   <= '0;
      blink_timer <= '0;
      blink_on    <= 1'b1;
      hit_q       <= 1'b1;
      bonus_q     <= 1'b1;
    end else begin
      state       <= state_nxt;
      lives       <= lives_nxt;
      lives_led   <= led_nxt;
      invuln      <= (state_nxt == INVULN);
      hit_ack     <= ack_nxt;
      die         <= (state_nxt == DEAD);
      inv_timer   <= inv_nxt;
      blink_timer <= blk_nxt;
      blink_on    <= blink_nxt;
      hit_q       <= hit;
      bonus_q     <= bonus;
    end
  end

endmodule

// File: tb/tb_life_manager.sv
// Bench for life_manager: directed scenarios followed by random traffic, all
// checked every cycle against an event-level model of lives and the hit window.
module tb_life_manager;

  localparam int MAXL   = 5;
  localparam int STARTL = 3;
  localparam int INV    = 8;
  localparam int BLK    = 2;
  localparam int LW     = $clog2(MAXL + 1);

  logic            clk = 1'b0;
  logic            rst;
  logic            game_start;
  logic            hit;
  logic            bonus;
  logic [LW-1:0]   lives;
  logic [MAXL-1:0] lives_led;
  logic            invuln;
  logic            hit_ack;
  logic            die;

  life_manager #(
    .MAX_LIVES    (MAXL),
    .START_LIVES  (STARTL),
    .INVULN_CYCLES(INV),
    .BLINK_CYCLES (BLK)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .game_start(game_start),
    .hit       (hit),
    .bonus     (bonus),
    .lives     (lives),
    .lives_led (lives_led),
    .invuln    (invuln),
    .hit_ack   (hit_ack),
    .die       (die)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // Model: lives count, dead flag, and "edges since the accepting hit" while invulnerable.
  int m_lives;
  bit m_dead;
  bit m_inv;
  int m_k;
  bit m_ack;
  bit m_ph;
  bit m_pb;

  function automatic void m_reset();
    m_lives = STARTL;
    m_dead  = 1'b0;
    m_inv   = 1'b0;
    m_k     = 0;
    m_ack   = 1'b0;
    m_ph    = 1'b1;
    m_pb    = 1'b1;
  endfunction

  function automatic void m_edge(bit gs, bit h, bit b);
    bit hr;
    bit br;
    hr    = h && !m_ph;
    br    = b && !m_pb;
    m_ph  = h;
    m_pb  = b;
    m_ack = 1'b0;
    if (gs) begin
      m_lives = STARTL;
      m_dead  = 1'b0;
      m_inv   = 1'b0;
    end else if (m_dead) begin
      m_lives = 0;
    end else if (m_inv) begin
      if (br && m_lives < MAXL) m_lives++;
      m_k++;
      if (m_k >= INV) m_inv = 1'b0;
    end else if (hr) begin
      m_ack = 1'b1;
      if (br) begin
        m_inv = 1'b1;
        m_k   = 0;
      end else if (m_lives > 1) begin
        m_lives--;
        m_inv = 1'b1;
        m_k   = 0;
      end else begin
        m_lives = 0;
        m_dead  = 1'b1;
      end
    end else if (br) begin
      if (m_lives < MAXL) m_lives++;
    end
  endfunction

  task automatic check(string tag);
    logic [MAXL-1:0] eled;
    bit              bl;
    bl = m_inv ? (((m_k / BLK) % 2) == 1) : 1'b1;
    for (int i = 0; i < MAXL; i++) eled[i] = (i < m_lives) && bl;
    n_cmp++;
    assert (lives === LW'(m_lives)) else begin
      n_err++; $error("FAIL %s lives: got %0d expected %0d", tag, lives, m_lives);
    end
    n_cmp++;
    assert (lives_led === eled) else begin
      n_err++; $error("FAIL %s lives_led: got %b expected %b", tag, lives_led, eled);
    end
    n_cmp++;
    assert (invuln === m_inv) else begin
      n_err++; $error("FAIL %s invuln: got %b expected %b", tag, invuln, m_inv);
    end
    n_cmp++;
    assert (hit_ack === m_ack) else begin
      n_err++; $error("FAIL %s hit_ack: got %b expected %b", tag, hit_ack, m_ack);
    end
    n_cmp++;
    assert (die === m_dead) else begin
      n_err++; $error("FAIL %s die: got %b expected %b", tag, die, m_dead);
    end
  endtask

  task automatic expect_out(string tag, int e_lives, logic [MAXL-1:0] e_led, bit e_inv, bit e_ack, bit e_die);
    n_cmp++;
    assert (lives === LW'(e_lives) && lives_led === e_led && invuln === e_inv &&
            hit_ack === e_ack && die === e_die) else begin
      n_err++;
      $error("FAIL %s: got lives=%0d led=%b inv=%b ack=%b die=%b expected lives=%0d led=%b inv=%b ack=%b die=%b",
             tag, lives, lives_led, invuln, hit_ack, die, e_lives, e_led, e_inv, e_ack, e_die);
    end
  endtask

  task automatic step(bit gs, bit h, bit b, string tag);
    @(negedge clk);
    game_start = gs;
    hit        = h;
    bonus      = b;
    @(posedge clk);
    m_edge(gs, h, b);
    #1;
    check(tag);
  endtask

  task automatic idle(int n, string tag);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, tag);
  endtask

  initial begin
    rst = 1'b1; game_start = 1'b0; hit = 1'b1; bonus = 1'b0;
    m_reset();
    repeat (2) @(posedge clk);
    #1;
    check("reset");
    expect_out("reset_const", 3, 5'b00111, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    rst = 1'b0;

    // 1: hit held high across reset release is never counted
    for (int i = 0; i < 20; i++) step(1'b0, 1'b1, 1'b0, "held_hit");
    expect_out("held_hit_const", 3, 5'b00111, 1'b0, 1'b0, 1'b0);

    // 2: single hit, blink pattern, window end
    step(1'b0, 1'b0, 1'b0, "pre_hit");
    step(1'b0, 1'b1, 1'b0, "hit1");
    expect_out("hit1_const", 2, 5'b00000, 1'b1, 1'b1, 1'b0);
    step(1'b0, 1'b1, 1'b0, "hit1_k1");
    expect_out("hit1_k1_const", 2, 5'b00000, 1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, "hit1_k2");
    expect_out("blink_on_const", 2, 5'b00011, 1'b1, 1'b0, 1'b0);
    // 3: re-hit three cycles into the window is ignored
    step(1'b0, 1'b1, 1'b0, "ignored_hit");
    idle(4, "window");
    step(1'b0, 1'b1, 1'b0, "last_ignored_edge");
    expect_out("window_end_const", 2, 5'b00011, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, "post_window");
    step(1'b0, 1'b1, 1'b0, "hit2");
    expect_out("hit2_const", 1, 5'b00000, 1'b1, 1'b1, 1'b0);
    idle(INV + 1, "window2");
    step(1'b0, 1'b1, 1'b0, "hit3");
    expect_out("death_const", 0, 5'b00000, 1'b0, 1'b1, 1'b1);

    // 4: dead ignores hit/bonus; game_start restarts
    step(1'b0, 1'b0, 1'b0, "dead0");
    step(1'b0, 1'b1, 1'b1, "dead_pulse");
    step(1'b0, 1'b0, 1'b0, "dead1");
    step(1'b0, 1'b0, 1'b1, "dead_bonus");
    expect_out("dead_const", 0, 5'b00000, 1'b0, 1'b0, 1'b1);
    step(1'b1, 1'b1, 1'b0, "restart");
    expect_out("restart_const", 3, 5'b00111, 1'b0, 1'b0, 1'b0);

    // 5: bonus saturation
    for (int i = 0; i < 4; i++) begin
      step(1'b0, 1'b0, 1'b0, "bonus_low");
      step(1'b0, 1'b0, 1'b1, "bonus_edge");
    end
    expect_out("saturate_const", 5, 5'b11111, 1'b0, 1'b0, 1'b0);

    // 6: down to one life, then hit+bonus together, then reset mid-window
    for (int i = 0; i < 4; i++) begin
      step(1'b0, 1'b0, 1'b0, "drain_low");
      step(1'b0, 1'b1, 1'b0, "drain_hit");
      idle(INV, "drain_wait");
    end
    expect_out("one_life_const", 1, 5'b00001, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b1, "hit_bonus");
    expect_out("hit_bonus_const", 1, 5'b00000, 1'b1, 1'b1, 1'b0);
    idle(2, "mid_window");
    @(negedge clk);
    #2 rst = 1'b1;
    m_reset();
    #1;
    check("mid_rst");
    expect_out("mid_rst_const", 3, 5'b00111, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    rst = 1'b0;

    // random traffic
    for (int i = 0; i < 600; i++) begin
      step(($urandom_range(0, 79) == 0), ($urandom_range(0, 2) == 0),
           ($urandom_range(0, 4) == 0), "random");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
